// File: rtl/fetch_exec_pkg.sv
// Shared definitions for the fetch/execute sequencer: FSM states and instruction field layout.
// Latency: none (types and constants only).
// Backpressure: none.
package fetch_exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Opcode occupies the top OP_W bits; dst sits DST_OFF bits below the MSB+1.
    localparam int OP_W    = 4;
    localparam int DST_OFF = 5;
    localparam int BR_BIT  = 3;
    localparam int MUX_BIT = 2;
    localparam logic [OP_W-1:0] OP_NOP = 4'b0111;

    // Branch offset is sign-magnitude in instr[OFF_W-1:0]; MSB set means forward.
    localparam int OFF_W    = 6;
    localparam int OFF_SIGN = OFF_W - 1;

    function automatic logic op_is_branch(input logic [OP_W-1:0] op);
        return op[BR_BIT];
    endfunction

    function automatic logic op_is_data(input logic [OP_W-1:0] op);
        return !op[BR_BIT] && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/fetch_exec_sequencer_pc_target_calc.sv
// Next-PC calculator: PC+1, or PC+1 +/- sign-magnitude offset when a branch is taken.
// Latency: combinational.
// Backpressure: none.
module pc_target_calc
    import fetch_exec_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    input  logic             taken,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] mag;

    always_comb begin
        seq_pc  = pc + PC_W'(1);
        mag     = PC_W'(offset[OFF_SIGN-1:0]);
        next_pc = seq_pc;
        if (taken) begin
            // Wraps modulo 2^PC_W in both directions.
            next_pc = offset[OFF_SIGN] ? (seq_pc + mag) : (seq_pc - mag);
        end
    end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/exec control FSM; optional fetch watchdog under FETCH_TIMEOUT_EN.
// Latency: 3 cycles per instruction with immediate ack, +1 per ack wait cycle.
// Backpressure: holds oImemReq/oImemAddr stable in FETCH until iImemAck.
module fetch_exec_sequencer
    import fetch_exec_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int INSTR_W     = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [PC_W-1:0]    iStartPC,
    input  logic               iHalt,
    input  logic               iImemAck,
    input  logic [INSTR_W-1:0] iImemData,
    input  logic               iBranchTaken,
    output logic               oImemReq,
    output logic [PC_W-1:0]    oImemAddr,
    output logic [INSTR_W-1:0] oInstr,
    output logic               oEnableA,
    output logic               oEnableB,
    output logic               oMuxSel,
    output logic [PC_W-1:0]    oPC,
    output logic               oBusy,
    output logic               oError
);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;
    logic [OP_W-1:0] op;
    logic            dst;
    logic            is_branch;
    logic            is_data;

    assign op        = oInstr[INSTR_W-1 -: OP_W];
    assign dst       = oInstr[INSTR_W-DST_OFF];
    assign is_branch = op_is_branch(op);
    assign is_data   = op_is_data(op);

    assign oPC       = pc_q;
    assign oImemAddr = pc_q;

    pc_target_calc #(
        .PC_W (PC_W)
    ) u_pc_target_calc (
        .pc      (pc_q),
        .offset  (oInstr[OFF_W-1:0]),
        .taken   (is_branch && iBranchTaken),
        .next_pc (pc_nxt)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (state == ST_FETCH) && !iImemAck && (tmo_cnt == TMO_LAST);

    // Idle at zero outside FETCH so every FETCH entry starts a fresh count.
    always_ff @(posedge Clock) begin
        if (Reset || state != ST_FETCH || iImemAck) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oError <= 1'b0;
        end else if (tmo_hit) begin
            oError <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign oError         = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            pc_q     <= '0;
            oInstr   <= '0;
            oImemReq <= 1'b0;
            oEnableA <= 1'b0;
            oEnableB <= 1'b0;
            oMuxSel  <= 1'b0;
            oBusy    <= 1'b0;
        end else begin
            oEnableA <= 1'b0;
            oEnableB <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart && !iHalt) begin
                        pc_q     <= iStartPC;
                        state    <= ST_FETCH;
                        oImemReq <= 1'b1;
                        oBusy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (iImemAck) begin
                        oInstr   <= iImemData;
                        oImemReq <= 1'b0;
                        state    <= ST_DECODE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        oImemReq <= 1'b0;
                        state    <= ST_ERROR;
                    end
`endif
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                    // Enables are registered here so they are high exactly during EXEC.
                    if (is_data) begin
                        oMuxSel  <= op[MUX_BIT];
                        oEnableA <= !dst;
                        oEnableB <= dst;
                    end
                end
                ST_EXEC: begin
                    pc_q <= pc_nxt;
                    if (iHalt) begin
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        state    <= ST_FETCH;
                        oImemReq <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state    <= ST_IDLE;
                    oImemReq <= 1'b0;
                    oBusy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Scoreboard bench for fetch_exec_sequencer: expected EXEC results queued at fetch, checked at commit.
module tb_fetch_exec_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [9:0]  iStartPC;
    logic        iHalt;
    logic        iImemAck;
    logic [15:0] iImemData;
    logic        iBranchTaken;
    logic        oImemReq;
    logic [9:0]  oImemAddr;
    logic [15:0] oInstr;
    logic        oEnableA;
    logic        oEnableB;
    logic        oMuxSel;
    logic [9:0]  oPC;
    logic        oBusy;
    logic        oError;

    fetch_exec_sequencer #(
        .PC_W        (10),
        .INSTR_W     (16),
        .TIMEOUT_CYC (15)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iStartPC     (iStartPC),
        .iHalt        (iHalt),
        .iImemAck     (iImemAck),
        .iImemData    (iImemData),
        .iBranchTaken (iBranchTaken),
        .oImemReq     (oImemReq),
        .oImemAddr    (oImemAddr),
        .oInstr       (oInstr),
        .oEnableA     (oEnableA),
        .oEnableB     (oEnableB),
        .oMuxSel      (oMuxSel),
        .oPC          (oPC),
        .oBusy        (oBusy),
        .oError       (oError)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       en_a;
        logic       en_b;
        logic       mux;
        logic [9:0] pc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [9:0] m_pc  = '0;
    logic       m_mux = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_next(input logic [9:0] pc, input logic [15:0] ins,
                                              input logic taken);
        int t;
        t = int'(pc) + 1;
        if (ins[15] && taken) begin
            if (ins[5]) t = t + int'(ins[4:0]);
            else        t = t - int'(ins[4:0]);
        end
        t = (t + 2048) % 1024;
        return 10'(t);
    endfunction

    task automatic start_at(input logic [9:0] pc);
        chk("idle_before_start", oBusy, 0);
        iStart   = 1'b1;
        iStartPC = pc;
        @(negedge Clock);
        iStart = 1'b0;
        chk("start_busy", oBusy, 1);
        chk("start_req", oImemReq, 1);
        m_pc = pc;
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after EXEC.
    task automatic run_instr(input logic [15:0] instr, input int wait_cyc,
                             input logic taken, input logic halt);
        exp_t e;
        exp_t g;
        logic data;
        data   = !instr[15] && (instr[15:12] != 4'b0111);
        e.pc   = model_next(m_pc, instr, taken);
        e.en_a = data && !instr[11];
        e.en_b = data && instr[11];
        if (data) m_mux = instr[14];
        e.mux  = m_mux;
        sb.push_back(e);

        for (int k = 0; k < wait_cyc; k++) begin
            chk("req_wait", oImemReq, 1);
            chk("addr_wait", oImemAddr, m_pc);
            chk("en_wait", {oEnableA, oEnableB}, 0);
            @(negedge Clock);
        end
        chk("req", oImemReq, 1);
        chk("addr", oImemAddr, m_pc);
        iImemAck  = 1'b1;
        iImemData = instr;
        iHalt     = halt;
        @(negedge Clock);
        iImemAck  = 1'b0;
        iImemData = 16'hFFFF;
        chk("req_drop", oImemReq, 0);
        chk("instr", oInstr, instr);
        chk("en_decode", {oEnableA, oEnableB}, 0);
        iBranchTaken = taken;
        @(negedge Clock);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            chk("en_a", oEnableA, g.en_a);
            chk("en_b", oEnableB, g.en_b);
            chk("mux", oMuxSel, g.mux);
            @(negedge Clock);
            iBranchTaken = 1'b0;
            iHalt        = 1'b0;
            chk("pc", oPC, g.pc);
            chk("busy_after", oBusy, !halt);
            chk("req_after", oImemReq, !halt);
            chk("en_after", {oEnableA, oEnableB}, 0);
            m_pc = g.pc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, oImemReq, 0);
        chk({tag, "_addr"}, oImemAddr, 0);
        chk({tag, "_instr"}, oInstr, 0);
        chk({tag, "_en"}, {oEnableA, oEnableB, oMuxSel}, 0);
        chk({tag, "_pc"}, oPC, 0);
        chk({tag, "_busy"}, oBusy, 0);
        chk({tag, "_err"}, oError, 0);
    endtask

    initial begin
        Reset        = 1'b1;
        iStart       = 1'b0;
        iStartPC     = '0;
        iHalt        = 1'b0;
        iImemAck     = 1'b0;
        iImemData    = '0;
        iBranchTaken = 1'b0;
        repeat (2) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clock);

        // Data ops, NOP, and iStart ignored while running.
        start_at(10'd5);
        run_instr(16'h0000, 0, 1'b0, 1'b0);
        iStart   = 1'b1;
        iStartPC = 10'd999;
        run_instr(16'h4800, 0, 1'b0, 1'b0);
        iStart = 1'b0;
        run_instr(16'h7000, 0, 1'b0, 1'b0);
        run_instr(16'h9823, 0, 1'b1, 1'b1);

        // Halt together with start keeps the sequencer idle.
        iStart   = 1'b1;
        iHalt    = 1'b1;
        iStartPC = 10'd50;
        @(negedge Clock);
        iStart = 1'b0;
        iHalt  = 1'b0;
        chk("halt_start_busy", oBusy, 0);
        chk("halt_start_req", oImemReq, 0);
        chk("halt_start_pc", oPC, m_pc);

        // Branch arithmetic from PC=20.
        start_at(10'd20);
        run_instr(16'h8023, 0, 1'b1, 1'b1);
        start_at(10'd20);
        run_instr(16'h8003, 0, 1'b1, 1'b1);
        start_at(10'd20);
        run_instr(16'h8023, 0, 1'b0, 1'b0);
        run_instr(16'h2000, 4, 1'b0, 1'b0);
        run_instr(16'h8000, 1, 1'b1, 1'b1);

        // Wrap-around in both directions.
        start_at(10'd1023);
        run_instr(16'h5800, 0, 1'b0, 1'b0);
        run_instr(16'h8005, 0, 1'b1, 1'b1);
        start_at(10'd2);
        run_instr(16'h8005, 2, 1'b1, 1'b1);

        // Ack while idle is ignored.
        iImemAck  = 1'b1;
        iImemData = 16'h1234;
        @(negedge Clock);
        iImemAck = 1'b0;
        chk("idle_ack_instr", oInstr, 16'h8005);
        chk("idle_ack_busy", oBusy, 0);

        // Reset mid-handshake.
        start_at(10'd100);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check_all_zero("mid_reset");
        Reset = 1'b0;
        @(negedge Clock);
        chk("post_reset_idle", oBusy, 0);

        start_at(10'd7);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            chk("tmo_pending_err", oError, 0);
            chk("tmo_pending_req", oImemReq, 1);
            @(negedge Clock);
        end
        chk("tmo_err", oError, 1);
        chk("tmo_req", oImemReq, 0);
        chk("tmo_busy", oBusy, 1);
        iImemAck = 1'b1;
        iStart   = 1'b1;
        repeat (3) @(negedge Clock);
        iImemAck = 1'b0;
        iStart   = 1'b0;
        chk("tmo_sticky_err", oError, 1);
        chk("tmo_sticky_busy", oBusy, 1);
`else
        repeat (20) @(negedge Clock);
        chk("no_tmo_err", oError, 0);
        chk("no_tmo_req", oImemReq, 1);
        chk("no_tmo_addr", oImemAddr, 10'd7);
`endif
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_all_zero("final_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
